ex_stage_unit: RTL and testbench

- Execute stage: the consumer end of the ID/EX pipeline register.
- Takes the registered ID/EX bundle, decodes ALU control, computes the ALU result and branch target, and drives the registered EX/MEM bundle.
- Contains an iterative 64-bit multiplier (MUL). While a multiply runs, the unit stalls IF/ID and ID/EX and inserts bubbles into EX/MEM.

---
 rtl/riscv_pipe_pkg.sv | 44 ++++
 rtl/mul_iter.sv | 69 ++++++
 rtl/ex_stage_unit.sv | 181 ++++++++++++++++++
 tb/tb_ex_stage_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
//------------------------------------------------------------------------------
// riscv_pipe_pkg : shared types and encodings for the RV64 pipeline stages.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package riscv_pipe_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] c_ALUOP_ADD2  = 2'b11;

  // Funct = {funct7[5], funct3}
  localparam logic [3:0] c_FUNCT_ADD = 4'b0000;
  localparam logic [3:0] c_FUNCT_SUB = 4'b1000;
  localparam logic [3:0] c_FUNCT_AND = 4'b0111;
  localparam logic [3:0] c_FUNCT_OR  = 4'b0110;
  localparam logic [3:0] c_FUNCT_XOR = 4'b0100;
  localparam logic [3:0] c_FUNCT_SLL = 4'b0001;
  localparam logic [3:0] c_FUNCT_SRL = 4'b0101;
  localparam logic [3:0] c_FUNCT_SRA = 4'b1101;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    SLL = 3'd5,
    SRL = 3'd6,
    SRA = 3'd7
  } alu_ctrl_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ex_state_e;

endpackage

`default_nettype wire

// File: rtl/mul_iter.sv
//------------------------------------------------------------------------------
// mul_iter : iterative shift-add multiplier, MUL_BITS multiplier bits per step.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mul_iter
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN     = riscv_pipe_pkg::XLEN,
  parameter int MUL_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int STEPS = XLEN / MUL_BITS;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] c_STEPS = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

  logic [XLEN-1:0]  r_mcand;
  logic [XLEN-1:0]  r_mplier;
  logic [XLEN-1:0]  r_acc;
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  w_partial;
  logic [XLEN-1:0]  w_acc_next;

  always_comb begin
    w_partial = '0;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (r_mplier[j]) w_partial = w_partial + (r_mcand << j);
    end
    w_acc_next = r_acc + w_partial;
  end

  // Product on the final step is taken straight from the adder so it can
  // register into EX/MEM on the same edge the count expires.
  assign done    = (r_count == c_ONE);
  assign product = w_acc_next;

  always_ff @(posedge clk) begin
    if (!reset || abort) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (start) begin
      r_mcand  <= multiplicand;
      r_mplier <= multiplier;
      r_acc    <= '0;
      r_count  <= c_STEPS;
    end else if (r_count != '0) begin
      r_mcand  <= r_mcand << MUL_BITS;
      r_mplier <= r_mplier >> MUL_BITS;
      r_acc    <= w_acc_next;
      r_count  <= r_count - c_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_stage_unit.sv
//------------------------------------------------------------------------------
// ex_stage_unit : execute stage, ALU + branch target + iterative MUL, EX/MEM reg.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ex_stage_unit
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN     = riscv_pipe_pkg::XLEN,
  parameter int MUL_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] ReadData1,
  input  logic [XLEN-1:0] ReadData2,
  input  logic [XLEN-1:0] imm_data,
  input  logic [4:0]      rd,
  input  logic [3:0]      Funct,
  input  logic [1:0]      ALUOp,
  input  logic            ALUSrc,
  input  logic            mul_en,
  input  logic            Branch,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            Regwrite,
  input  logic            MemtoReg,
  output logic            stall_req,
  output logic [XLEN-1:0] PC_branch_out,
  output logic            zero_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] write_data_out,
  output logic [4:0]      rd_out,
  output logic            Branch_out,
  output logic            MemRead_out,
  output logic            MemWrite_out,
  output logic            Regwrite_out,
  output logic            MemtoReg_out
);

  localparam int SH_W = $clog2(XLEN);

  ex_state_e       r_state, w_state_next;
  alu_ctrl_e       w_alu_ctrl;
  logic [XLEN-1:0] w_op_b, w_alu_res, w_mul_prod;
  logic [SH_W-1:0] w_shamt;
  logic            w_mul_start, w_mul_done;
  logic [4:0]      r_hold_rd;
  logic [4:0]      r_hold_ctrl;   // {Branch, MemRead, MemWrite, Regwrite, MemtoReg}
  logic            w_load;
  logic [XLEN-1:0] w_result;
  logic [4:0]      w_rd, w_ctrl;

  assign w_op_b  = ALUSrc ? imm_data : ReadData2;
  assign w_shamt = w_op_b[SH_W-1:0];

  always_comb begin
    w_alu_ctrl = ADD;
    case (ALUOp)
      c_ALUOP_SUB: w_alu_ctrl = SUB;
      c_ALUOP_RTYPE: begin
        case (Funct)
          c_FUNCT_SUB: w_alu_ctrl = SUB;
          c_FUNCT_AND: w_alu_ctrl = AND;
          c_FUNCT_OR:  w_alu_ctrl = OR;
          c_FUNCT_XOR: w_alu_ctrl = XOR;
          c_FUNCT_SLL: w_alu_ctrl = SLL;
          c_FUNCT_SRL: w_alu_ctrl = SRL;
          c_FUNCT_SRA: w_alu_ctrl = SRA;
          default:     w_alu_ctrl = ADD;
        endcase
      end
      default: w_alu_ctrl = ADD;
    endcase
  end

  always_comb begin
    w_alu_res = '0;
    case (w_alu_ctrl)
      ADD: w_alu_res = ReadData1 + w_op_b;
      SUB: w_alu_res = ReadData1 - w_op_b;
      AND: w_alu_res = ReadData1 & w_op_b;
      OR:  w_alu_res = ReadData1 | w_op_b;
      XOR: w_alu_res = ReadData1 ^ w_op_b;
      SLL: w_alu_res = ReadData1 << w_shamt;
      SRL: w_alu_res = ReadData1 >> w_shamt;
      SRA: w_alu_res = $signed(ReadData1) >>> w_shamt;
      default: w_alu_res = '0;
    endcase
  end

  assign w_mul_start = (r_state == IDLE) && in_valid && mul_en && !flush;

  mul_iter #(
    .XLEN     (XLEN),
    .MUL_BITS (MUL_BITS)
  ) u_mul_iter (
    .clk          (clk),
    .reset        (reset),
    .start        (w_mul_start),
    .abort        (flush),
    .multiplicand (ReadData1),
    .multiplier   (w_op_b),
    .done         (w_mul_done),
    .product      (w_mul_prod)
  );

  always_comb begin
    w_state_next = r_state;
    stall_req    = 1'b0;
    w_load       = 1'b0;
    w_result     = w_alu_res;
    w_rd         = rd;
    w_ctrl       = {Branch, MemRead, MemWrite, Regwrite, MemtoReg};
    if (!flush) begin
      case (r_state)
        IDLE: begin
          if (in_valid && mul_en) begin
            stall_req    = 1'b1;
            w_state_next = BUSY;
          end else begin
            w_load = in_valid;
          end
        end
        BUSY: begin
          if (w_mul_done) begin
            w_load       = 1'b1;
            w_result     = w_mul_prod;
            w_rd         = r_hold_rd;
            w_ctrl       = r_hold_ctrl;
            w_state_next = IDLE;
          end else begin
            stall_req = 1'b1;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end else begin
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_hold_rd   <= '0;
      r_hold_ctrl <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_mul_start) begin
        r_hold_rd   <= rd;
        r_hold_ctrl <= {Branch, MemRead, MemWrite, Regwrite, MemtoReg};
      end
    end
  end

  // Anything not explicitly loaded (invalid, flushed, MUL in flight) is a bubble.
  always_ff @(posedge clk) begin
    if (!reset || !w_load) begin
      PC_branch_out  <= '0;
      zero_out       <= 1'b0;
      alu_result_out <= '0;
      write_data_out <= '0;
      rd_out         <= '0;
      {Branch_out, MemRead_out, MemWrite_out, Regwrite_out, MemtoReg_out} <= 5'b0;
    end else begin
      PC_branch_out  <= PC + (imm_data << 1);
      zero_out       <= (w_result == '0);
      alu_result_out <= w_result;
      write_data_out <= ReadData2;
      rd_out         <= w_rd;
      {Branch_out, MemRead_out, MemWrite_out, Regwrite_out, MemtoReg_out} <= w_ctrl;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_stage_unit.sv
//------------------------------------------------------------------------------
// tb_ex_stage_unit : directed self-checking bench for ex_stage_unit.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ex_stage_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, flush;
  logic [63:0] PC, ReadData1, ReadData2, imm_data;
  logic [4:0]  rd;
  logic [3:0]  Funct;
  logic [1:0]  ALUOp;
  logic        ALUSrc, mul_en, Branch, MemRead, MemWrite, Regwrite, MemtoReg;
  logic        stall_req;
  logic [63:0] PC_branch_out, alu_result_out, write_data_out;
  logic        zero_out;
  logic [4:0]  rd_out;
  logic        Branch_out, MemRead_out, MemWrite_out, Regwrite_out, MemtoReg_out;

  int n_checks = 0;
  int n_errors = 0;

  ex_stage_unit #(.XLEN(64), .MUL_BITS(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .flush          (flush),
    .PC             (PC),
    .ReadData1      (ReadData1),
    .ReadData2      (ReadData2),
    .imm_data       (imm_data),
    .rd             (rd),
    .Funct          (Funct),
    .ALUOp          (ALUOp),
    .ALUSrc         (ALUSrc),
    .mul_en         (mul_en),
    .Branch         (Branch),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .Regwrite       (Regwrite),
    .MemtoReg       (MemtoReg),
    .stall_req      (stall_req),
    .PC_branch_out  (PC_branch_out),
    .zero_out       (zero_out),
    .alu_result_out (alu_result_out),
    .write_data_out (write_data_out),
    .rd_out         (rd_out),
    .Branch_out     (Branch_out),
    .MemRead_out    (MemRead_out),
    .MemWrite_out   (MemWrite_out),
    .Regwrite_out   (Regwrite_out),
    .MemtoReg_out   (MemtoReg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [3:0] fn, input logic src,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm);
    in_valid = 1'b1; mul_en = 1'b0; flush = 1'b0;
    ALUOp = op; Funct = fn; ALUSrc = src;
    ReadData1 = a; ReadData2 = b; imm_data = imm;
  endtask

  function automatic logic [4:0] ctrls();
    return {Branch_out, MemRead_out, MemWrite_out, Regwrite_out, MemtoReg_out};
  endfunction

  initial begin
    int n;
    int bad_bubbles;

    // Reset with nonzero inputs applied
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; mul_en = 1'b0;
    PC = 64'h40; ReadData1 = 64'd11; ReadData2 = 64'd22; imm_data = 64'd3;
    rd = 5'd3; Funct = 4'b0000; ALUOp = 2'b10; ALUSrc = 1'b0;
    Branch = 1'b1; MemRead = 1'b1; MemWrite = 1'b1; Regwrite = 1'b1; MemtoReg = 1'b1;
    tick(); tick();
    check("rst_alu", alu_result_out, 64'd0);
    check("rst_pcbr", PC_branch_out, 64'd0);
    check("rst_wdata", write_data_out, 64'd0);
    check("rst_rd", {59'd0, rd_out}, 64'd0);
    check("rst_ctrl", {59'd0, ctrls()}, 64'd0);
    check("rst_zero", {63'd0, zero_out}, 64'd0);
    check("rst_stall", {63'd0, stall_req}, 64'd0);

    // R-type sub
    reset = 1'b1;
    Branch = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Regwrite = 1'b1; MemtoReg = 1'b0;
    rd = 5'd5;
    set_op(2'b10, 4'b1000, 1'b0, 64'd10, 64'd3, 64'd0);
    #1 check("sub_stall", {63'd0, stall_req}, 64'd0);
    tick();
    check("sub_res", alu_result_out, 64'd7);
    check("sub_zero", {63'd0, zero_out}, 64'd0);
    check("sub_regw", {63'd0, Regwrite_out}, 64'd1);
    check("sub_rd", {59'd0, rd_out}, 64'd5);
    check("sub_wdata", write_data_out, 64'd3);

    // sra
    set_op(2'b10, 4'b1101, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd0);
    tick();
    check("sra_res", alu_result_out, 64'hF800_0000_0000_0000);

    // srl, and, xor, sll using only B[5:0], unknown funct decodes to add
    set_op(2'b10, 4'b0101, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd0);
    tick();
    check("srl_res", alu_result_out, 64'h0800_0000_0000_0000);
    set_op(2'b10, 4'b0111, 1'b0, 64'hF0, 64'h3C, 64'd0);
    tick();
    check("and_res", alu_result_out, 64'h30);
    set_op(2'b10, 4'b0110, 1'b0, 64'hF0, 64'h3C, 64'd0);
    tick();
    check("or_res", alu_result_out, 64'hFC);
    set_op(2'b10, 4'b0100, 1'b0, 64'hF0, 64'h3C, 64'd0);
    tick();
    check("xor_res", alu_result_out, 64'hCC);
    set_op(2'b10, 4'b0001, 1'b0, 64'd1, 64'd68, 64'd0);
    tick();
    check("sll_res", alu_result_out, 64'd16);
    set_op(2'b10, 4'b0010, 1'b0, 64'd9, 64'd6, 64'd0);
    tick();
    check("dflt_add", alu_result_out, 64'd15);
    set_op(2'b00, 4'b0000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    tick();
    check("add_wrap", alu_result_out, 64'd0);
    check("add_wrap_z", {63'd0, zero_out}, 64'd1);

    // Branch compare
    Branch = 1'b1; Regwrite = 1'b0;
    PC = 64'h100;
    set_op(2'b01, 4'b0000, 1'b0, 64'd5, 64'd5, 64'd8);
    tick();
    check("br_zero", {63'd0, zero_out}, 64'd1);
    check("br_target", PC_branch_out, 64'h110);
    check("br_ctrl", {63'd0, Branch_out}, 64'd1);

    // MUL -1 * 3
    Branch = 1'b0; Regwrite = 1'b1; rd = 5'd7; PC = 64'h200;
    set_op(2'b10, 4'b0000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd0);
    mul_en = 1'b1;
    #1;
    n = 0; bad_bubbles = 0;
    while (stall_req && n < 40) begin
      tick();
      n++;
      if (ctrls() != 5'd0 || alu_result_out != 64'd0) bad_bubbles++;
    end
    check("mul_stall_cyc", 64'(n), 64'd32);
    check("mul_bubbles", 64'(bad_bubbles), 64'd0);
    check("mul_last_stall", {63'd0, stall_req}, 64'd0);
    tick();
    set_op(2'b00, 4'b0000, 1'b0, 64'd20, 64'd22, 64'd0);
    rd = 5'd8;
    check("mul_res", alu_result_out, 64'hFFFF_FFFF_FFFF_FFFD);
    check("mul_regw", {63'd0, Regwrite_out}, 64'd1);
    check("mul_rd", {59'd0, rd_out}, 64'd7);
    check("mul_zero", {63'd0, zero_out}, 64'd0);
    check("mul_pcbr", PC_branch_out, 64'h200);
    #1 check("add_after_stall", {63'd0, stall_req}, 64'd0);
    tick();
    check("add_after_mul", alu_result_out, 64'd42);
    check("add_after_rd", {59'd0, rd_out}, 64'd8);

    // Flush at BUSY count=10
    rd = 5'd9;
    set_op(2'b10, 4'b0000, 1'b0, 64'd5, 64'd7, 64'd0);
    mul_en = 1'b1;
    for (int i = 0; i < 23; i++) tick();
    flush = 1'b1;
    #1 check("flush_stall", {63'd0, stall_req}, 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; mul_en = 1'b0;
    check("flush_bubble", {59'd0, ctrls()}, 64'd0);
    check("flush_alu", alu_result_out, 64'd0);
    bad_bubbles = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (alu_result_out == 64'd35 || Regwrite_out || stall_req) bad_bubbles++;
    end
    check("flush_no_prod", 64'(bad_bubbles), 64'd0);
    set_op(2'b00, 4'b0000, 1'b0, 64'd1, 64'd2, 64'd0);
    #1 check("flush_idle_stall", {63'd0, stall_req}, 64'd0);
    tick();
    check("flush_idle_add", alu_result_out, 64'd3);

    // Bubble then load
    Branch = 1'b1; MemRead = 1'b1; MemWrite = 1'b1; Regwrite = 1'b1; MemtoReg = 1'b1;
    in_valid = 1'b0;
    tick();
    check("bub_ctrl", {59'd0, ctrls()}, 64'd0);
    check("bub_pcbr", PC_branch_out, 64'd0);
    Branch = 1'b0; MemWrite = 1'b0;
    set_op(2'b00, 4'b0000, 1'b1, 64'h200, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8);
    tick();
    check("ld_addr", alu_result_out, 64'h1F8);
    check("ld_memrd", {63'd0, MemRead_out}, 64'd1);
    check("ld_ctrl", {59'd0, ctrls()}, 64'h0B);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
